// File: rtl/rf_2p_rd_stream.sv
// Burst read controller for a 2-port register file: issues RF port A reads
// and streams the returned words through a 2-entry FIFO on a valid/ready port.
module rf_2p_rd_stream #(
    parameter int Word_Width = 256,
    parameter int Addr_Width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [Addr_Width-1:0] base_i,
    input  logic [Addr_Width:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rf_cena_o,
    output logic [Addr_Width-1:0] rf_addra_o,
    input  logic [Word_Width-1:0] rf_dataa_i,
    output logic                  dat_val_o,
    output logic [Word_Width-1:0] dat_o,
    output logic                  dat_last_o,
    input  logic                  dat_rdy_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [Addr_Width:0] LenZero = {(Addr_Width+1){1'b0}};
    localparam logic [Addr_Width:0] LenOne  = {{Addr_Width{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [Addr_Width-1:0]   base_q, base_d;
    logic [Addr_Width:0]     len_q, len_d;
    logic [Addr_Width:0]     issued_q, issued_d;
    logic [Addr_Width:0]     popped_q, popped_d;
    logic [Addr_Width-1:0]   last_addr_q, last_addr_d;
    logic                    inflight_q, inflight_d;
    logic [Word_Width-1:0]   mem0_q, mem0_d;
    logic [Word_Width-1:0]   mem1_q, mem1_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic                    pop_s;
    logic                    issue_s;
    logic [2:0]              outstanding_s;
    logic [Addr_Width-1:0]   issue_addr_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= {Addr_Width{1'b0}};
            len_q       <= LenZero;
            issued_q    <= LenZero;
            popped_q    <= LenZero;
            last_addr_q <= {Addr_Width{1'b0}};
            inflight_q  <= 1'b0;
            mem0_q      <= {Word_Width{1'b0}};
            mem1_q      <= {Word_Width{1'b0}};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            mem0_q      <= mem0_d;
            mem1_q      <= mem1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == LenZero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && dat_last_o) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and issue decision; outstanding counts words held plus the one in flight
    always_comb begin
        busy_o        = (state_q != ST_IDLE);
        done_o        = (state_q == ST_DONE);
        dat_val_o     = (fifo_cnt_q != 2'd0);
        pop_s         = dat_val_o & dat_rdy_i;
        dat_o         = rd_ptr_q ? mem1_q : mem0_q;
        dat_last_o    = dat_val_o && (popped_q == (len_q - LenOne));
        outstanding_s = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_addr_s  = base_q + issued_q[Addr_Width-1:0];
        issue_s       = (state_q == ST_RUN) && (issued_q < len_q) && (outstanding_s < 3'd2);
        rf_cena_o     = ~issue_s;
        rf_addra_o    = issue_s ? issue_addr_s : last_addr_q;
    end

    // Command latch, counters and FIFO update
    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        last_addr_d = last_addr_q;
        mem0_d      = mem0_q;
        mem1_d      = mem1_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = issue_s;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};

        if ((state_q == ST_IDLE) && start_i && (len_i != LenZero)) begin
            base_d   = base_i;
            len_d    = len_i;
            issued_d = LenZero;
            popped_d = LenZero;
        end else if (issue_s) begin
            issued_d    = issued_q + LenOne;
            last_addr_d = issue_addr_s;
        end else begin
            issued_d = issued_q;
        end

        // RF data lands one cycle after its issue
        if (inflight_q) begin
            if (wr_ptr_q) begin
                mem1_d = rf_dataa_i;
            end else begin
                mem0_d = rf_dataa_i;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
            popped_d = popped_q + LenOne;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_rf_2p_rd_stream.sv
// Bench for rf_2p_rd_stream: an RF memory model plus a count-based burst model
// that predicts every cycle's RF access and stream output.
module tb_rf_2p_rd_stream;
    localparam int WW = 256;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_i;
    logic [AW:0]   len_i;
    logic          busy_o, done_o, rf_cena_o;
    logic [AW-1:0] rf_addra_o;
    logic [WW-1:0] rf_dataa_i;
    logic          dat_val_o, dat_last_o, dat_rdy_i;
    logic [WW-1:0] dat_o;

    int checks   = 0;
    int failures = 0;

    logic [WW-1:0] rf_mem [512];

    rf_2p_rd_stream #(.Word_Width(WW), .Addr_Width(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .rf_cena_o(rf_cena_o), .rf_addra_o(rf_addra_o),
        .rf_dataa_i(rf_dataa_i), .dat_val_o(dat_val_o), .dat_o(dat_o),
        .dat_last_o(dat_last_o), .dat_rdy_i(dat_rdy_i)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // RF port A: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        if (!rf_cena_o) rf_dataa_i <= rf_mem[rf_addra_o];
        else            rf_dataa_i <= rand_word();
    end

    // Burst model state
    bit      chk_en = 1'b0;
    bit      active = 1'b0;
    int      cyc, m_base, m_len, n_iss, n_pop, iss_m2, last_pop, iss_start;
    int      first_iss, first_val, done_seen, last_word, idle_cyc, words;
    int      m_last_addr = 0;
    int      addr_log[$];
    bit      exp_val, pop_now, exp_issue, exp_busy;

    // Per-cycle comparison against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (active) begin
                    cyc++;
                    iss_start = n_iss;
                    exp_val   = (iss_m2 - n_pop) > 0;
                    pop_now   = exp_val && dat_rdy_i;
                    exp_issue = (n_iss < m_len) && ((n_iss - n_pop - int'(pop_now)) < 2);
                    exp_busy  = cyc <= last_pop + 1;
                    chki("busy", 32'(busy_o), 32'(exp_busy));
                    chki("done", 32'(done_o), 32'(cyc == last_pop + 1));
                    chki("dat_val", 32'(dat_val_o), 32'(exp_val));
                    chki("rf_cena", 32'(rf_cena_o), 32'(!exp_issue));
                    if (dat_val_o && first_val < 0) first_val = cyc;
                    if (done_o) done_seen = cyc;
                    if (exp_val) begin
                        chk("dat", dat_o, rf_mem[(m_base + n_pop) % 512]);
                        chki("dat_last", 32'(dat_last_o), 32'(n_pop == m_len - 1));
                    end
                    if (!rf_cena_o) begin
                        chki("rf_addr", 32'(rf_addra_o), 32'((m_base + n_iss) % 512));
                        m_last_addr = (m_base + n_iss) % 512;
                        addr_log.push_back(int'(rf_addra_o));
                        if (first_iss < 0) first_iss = cyc;
                        n_iss++;
                    end else begin
                        chki("rf_addr_hold", 32'(rf_addra_o), 32'(m_last_addr));
                    end
                    if (pop_now) begin
                        n_pop++;
                        words++;
                        if (dat_last_o) last_word = cyc;
                        if (n_pop == m_len) last_pop = cyc;
                    end
                    chki("outstanding_le2", 32'(n_iss - n_pop <= 2), 32'd1);
                    iss_m2 = iss_start;
                    if (!exp_busy) begin
                        active   = 1'b0;
                        idle_cyc = cyc;
                    end
                end else begin
                    chki("idle_busy", 32'(busy_o), 32'd0);
                    chki("idle_done", 32'(done_o), 32'd0);
                    chki("idle_cena", 32'(rf_cena_o), 32'd1);
                    chki("idle_val", 32'(dat_val_o), 32'd0);
                    chki("idle_addr", 32'(rf_addra_o), 32'(m_last_addr));
                end
                if (rst) begin
                    active      = 1'b0;
                    m_last_addr = 0;
                end else if (!active && start_i) begin
                    m_base = int'(base_i); m_len = int'(len_i);
                    cyc = 0; n_iss = 0; n_pop = 0; iss_m2 = 0; words = 0;
                    last_pop  = (len_i == 10'd0) ? 0 : 1000000;
                    first_iss = -1; first_val = -1; done_seen = -1;
                    last_word = -1; idle_cyc = -1;
                    addr_log.delete();
                    active = 1'b1;
                end
            end
        end
    end

    // Drive one command; mode 1 randomizes ready with a 5-cycle low window
    task automatic run_burst(input int b, input int l, input int mode, input int rst_at, input int inj);
        base_i    = AW'(b);
        len_i     = (AW+1)'(l);
        start_i   = 1'b1;
        dat_rdy_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        base_i  = AW'($urandom);
        len_i   = (AW+1)'($urandom);
        for (int c = 1; c <= 3000; c++) begin
            if (mode == 1) dat_rdy_i = (c >= 5 && c <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
            else           dat_rdy_i = 1'b1;
            if (c == inj) begin
                start_i = 1'b1;
                base_i  = AW'(b + 100);
                len_i   = 10'd3;
            end else begin
                start_i = 1'b0;
            end
            if (c == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            rst     = 1'b0;
            start_i = 1'b0;
            if (!active) break;
        end
        chki("burst_finished", 32'(active), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; dat_rdy_i = 1'b0;
        for (int a = 0; a < 512; a++) begin
            rf_mem[a] = rand_word();
            rf_mem[a][15:0] = 16'(a);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chki("rst_busy", 32'(busy_o), 32'd0);
        chki("rst_done", 32'(done_o), 32'd0);
        chki("rst_cena", 32'(rf_cena_o), 32'd1);
        chki("rst_addr", 32'(rf_addra_o), 32'd0);
        chki("rst_val", 32'(dat_val_o), 32'd0);
        chki("rst_last", 32'(dat_last_o), 32'd0);
        chk("rst_dat", dat_o, {WW{1'b0}});
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_burst(16, 4, 0, 0, 0);
        chki("t1_first_issue", 32'(first_iss), 32'd1);
        chki("t1_first_val", 32'(first_val), 32'd3);
        chki("t1_last_word", 32'(last_word), 32'd6);
        chki("t1_done", 32'(done_seen), 32'd7);
        chki("t1_idle", 32'(idle_cyc), 32'd8);
        chki("t1_words", 32'(words), 32'd4);
        chki("t1_addr3", 32'(addr_log[3]), 32'h13);

        run_burst(510, 4, 0, 0, 0);
        chki("wrap_n", 32'(addr_log.size()), 32'd4);
        chki("wrap_a0", 32'(addr_log[0]), 32'd510);
        chki("wrap_a1", 32'(addr_log[1]), 32'd511);
        chki("wrap_a2", 32'(addr_log[2]), 32'd0);
        chki("wrap_a3", 32'(addr_log[3]), 32'd1);
        chki("wrap_last", 32'(last_word), 32'(idle_cyc - 2));

        run_burst(100, 8, 1, 0, 0);
        chki("bp_words", 32'(words), 32'd8);

        run_burst(200, 0, 0, 0, 0);
        chki("len0_done", 32'(done_seen), 32'd1);
        chki("len0_idle", 32'(idle_cyc), 32'd2);
        chki("len0_issues", 32'(addr_log.size()), 32'd0);
        chki("len0_words", 32'(words), 32'd0);

        run_burst(300, 6, 0, 0, 3);
        chki("inj_words", 32'(words), 32'd6);
        chki("inj_base", 32'(addr_log[0]), 32'd300);

        run_burst(50, 16, 0, 4, 0);
        @(negedge clk);
        chki("rst_mid_cena", 32'(rf_cena_o), 32'd1);
        chki("rst_mid_val", 32'(dat_val_o), 32'd0);
        chki("rst_mid_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        run_burst(60, 2, 0, 0, 0);
        chki("post_rst_words", 32'(words), 32'd2);

        for (int k = 0; k < 6; k++) begin
            run_burst($urandom_range(0, 511), $urandom_range(1, 40), k % 2, 0, 0);
        end
        run_burst($urandom_range(0, 511), 512, 0, 0, 0);
        chki("full_words", 32'(words), 32'd512);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
